// File: rtl/sm_directory_pkg.sv
// sm_directory_pkg: shared encodings for the MSI home-node directory
package sm_directory_pkg;
  localparam logic [1:0] DIR_DI = 2'b00;
  localparam logic [1:0] DIR_DS = 2'b01;
  localparam logic [1:0] DIR_DM = 2'b10;
  localparam logic [1:0] REQ_NONE       = 2'b00;
  localparam logic [1:0] REQ_READ_MISS  = 2'b01;
  localparam logic [1:0] REQ_WRITE_MISS = 2'b10;
  localparam logic [1:0] REQ_WRITE_BACK = 2'b11;
  localparam logic [0:0] CTL_IDLE       = 1'b0;
  localparam logic [0:0] CTL_FETCH_WAIT = 1'b1;
endpackage

// File: rtl/dir_onehot_enc.sv
// dir_onehot_enc: converts a one-hot vector to the index of its set bit
module dir_onehot_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] index_o
);
  // OR together the indices of all set bits; exact for a one-hot input
  always_comb begin
    index_o = '0;
    for (int i = 0; i < N; i++)
      index_o = onehot_i[i] ? (index_o | W'(i)) : index_o;
  end
endmodule

// File: rtl/sm_directory_multi.sv
// sm_directory_multi: MSI directory controller with owner fetch, invalidation and replies
module sm_directory_multi
  import sm_directory_pkg::*;
#(
  parameter  int NUM_PROCS  = 2,
  parameter  int NUM_BLOCKS = 4,
  localparam int PID_W      = $clog2(NUM_PROCS),
  localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [PID_W-1:0]     req_proc,
  input  logic [BLK_W-1:0]     req_block,
  output logic                 fetch,
  output logic [PID_W-1:0]     fetch_proc,
  input  logic                 fetch_done,
  output logic                 invalidate,
  output logic [NUM_PROCS-1:0] invalidate_mask,
  output logic                 data_value_reply,
  output logic [PID_W-1:0]     reply_proc,
  output logic                 protocol_err,
  output logic [NUM_PROCS-1:0] sharers,
  output logic [1:0]           current_state
);
  logic [1:0]           state_q [NUM_BLOCKS];
  logic [NUM_PROCS-1:0] shr_q   [NUM_BLOCKS];
  logic [0:0]           ctl_q, ctl_d;
  logic [PID_W-1:0]     pend_proc_q, pend_proc_d, fetch_proc_q, fetch_proc_d, reply_proc_q, reply_proc_d;
  logic [BLK_W-1:0]     pend_blk_q, pend_blk_d;
  logic                 pend_wr_q, pend_wr_d, fetch_q, fetch_d, inv_q, inv_d, reply_q, reply_d, err_q, err_d;
  logic [NUM_PROCS-1:0] inv_mask_q, inv_mask_d, sharers_q;
  logic [1:0]           cur_q;
  logic                 acc, blk_ok, proc_ok, upd;
  logic [BLK_W-1:0]     blk;
  logic [1:0]           st, upd_state;
  logic [NUM_PROCS-1:0] shr, p_vec, o_vec, pend_vec, upd_shr;
  logic [PID_W-1:0]     owner;
  assign req_ready        = ctl_q == CTL_IDLE;
  assign acc              = req_valid && req_ready && req_type != REQ_NONE;
  assign blk_ok           = {1'b0, req_block} < (BLK_W+1)'(NUM_BLOCKS);
  assign proc_ok          = {1'b0, req_proc} < (PID_W+1)'(NUM_PROCS);
  assign blk              = (ctl_q == CTL_FETCH_WAIT) ? pend_blk_q : (blk_ok ? req_block : '0);
  assign st               = state_q[blk];
  assign shr              = shr_q[blk];
  assign p_vec            = NUM_PROCS'(1) << req_proc;
  assign o_vec            = NUM_PROCS'(1) << owner;
  assign pend_vec         = NUM_PROCS'(1) << pend_proc_q;
  assign fetch            = fetch_q;
  assign fetch_proc       = fetch_proc_q;
  assign invalidate       = inv_q;
  assign invalidate_mask  = inv_mask_q;
  assign data_value_reply = reply_q;
  assign reply_proc       = reply_proc_q;
  assign protocol_err     = err_q;
  assign sharers          = sharers_q;
  assign current_state    = cur_q;
  dir_onehot_enc #(.N(NUM_PROCS), .W(PID_W)) u_enc (
    .onehot_i (shr),
    .index_o  (owner)
  );
  // Protocol decisions: complete a pending fetch, or act on a newly accepted request
  always_comb begin
    ctl_d        = ctl_q;
    pend_proc_d  = pend_proc_q;
    pend_blk_d   = pend_blk_q;
    pend_wr_d    = pend_wr_q;
    fetch_d      = fetch_q;
    fetch_proc_d = fetch_proc_q;
    reply_proc_d = reply_proc_q;
    inv_d        = 1'b0;
    inv_mask_d   = '0;
    reply_d      = 1'b0;
    err_d        = 1'b0;
    upd          = 1'b0;
    upd_state    = st;
    upd_shr      = shr;
    if (ctl_q == CTL_FETCH_WAIT) begin
      if (fetch_done) begin
        ctl_d        = CTL_IDLE;
        fetch_d      = 1'b0;
        reply_d      = 1'b1;
        reply_proc_d = pend_proc_q;
        upd          = 1'b1;
        upd_state    = pend_wr_q ? DIR_DM : DIR_DS;
        upd_shr      = pend_wr_q ? pend_vec : (o_vec | pend_vec);
      end
    end else if (acc) begin
      if (!blk_ok || !proc_ok) begin
        err_d = 1'b1;
      end else if (req_type == REQ_WRITE_BACK) begin
        upd       = st == DIR_DM && shr == p_vec;
        err_d     = !upd;
        upd_state = DIR_DI;
        upd_shr   = '0;
      end else if (st == DIR_DM) begin
        if (shr == p_vec) begin
          err_d = 1'b1;
        end else begin
          ctl_d        = CTL_FETCH_WAIT;
          fetch_d      = 1'b1;
          fetch_proc_d = owner;
          pend_proc_d  = req_proc;
          pend_blk_d   = blk;
          pend_wr_d    = req_type == REQ_WRITE_MISS;
          inv_d        = pend_wr_d;
          inv_mask_d   = pend_wr_d ? o_vec : '0;
        end
      end else begin
        reply_d      = 1'b1;
        reply_proc_d = req_proc;
        upd          = 1'b1;
        upd_state    = (req_type == REQ_READ_MISS) ? DIR_DS : DIR_DM;
        upd_shr      = (req_type == REQ_READ_MISS) ? (shr | p_vec) : p_vec;
        inv_mask_d   = (req_type == REQ_READ_MISS) ? '0 : (shr & ~p_vec);
        inv_d        = |inv_mask_d;
      end
    end
  end
  // Directory storage, controller state and registered responses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        state_q[i] <= DIR_DI;
        shr_q[i]   <= '0;
      end
      ctl_q        <= CTL_IDLE;
      pend_proc_q  <= '0;
      pend_blk_q   <= '0;
      pend_wr_q    <= 1'b0;
      fetch_q      <= 1'b0;
      fetch_proc_q <= '0;
      inv_q        <= 1'b0;
      inv_mask_q   <= '0;
      reply_q      <= 1'b0;
      reply_proc_q <= '0;
      err_q        <= 1'b0;
      sharers_q    <= '0;
      cur_q        <= DIR_DI;
    end else begin
      ctl_q        <= ctl_d;
      pend_proc_q  <= pend_proc_d;
      pend_blk_q   <= pend_blk_d;
      pend_wr_q    <= pend_wr_d;
      fetch_q      <= fetch_d;
      fetch_proc_q <= fetch_proc_d;
      inv_q        <= inv_d;
      inv_mask_q   <= inv_mask_d;
      reply_q      <= reply_d;
      reply_proc_q <= reply_proc_d;
      err_q        <= err_d;
      if (upd) begin
        state_q[blk] <= upd_state;
        shr_q[blk]   <= upd_shr;
        sharers_q    <= upd_shr;
        cur_q        <= upd_state;
      end
    end
  end
endmodule
